// File: rtl/l1_mshr_file.sv
// l1_mshr_file: L1D miss-status holding registers with secondary-miss merging, single LC issue per line and in-order target replay
module l1_mshr_file #(
  parameter int MSHR_COUNT = 4,
  parameter int TARGETS    = 4,
  parameter int B          = 64,
  parameter int PADDR_BITS = 22
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic                  req_we_in,
  input  logic [63:0]           req_value_in,
  output logic                  lc_valid_out,
  input  logic                  lc_ready_in,
  output logic [PADDR_BITS-1:0] lc_addr_out,
  input  logic                  fill_valid_in,
  input  logic [PADDR_BITS-1:0] fill_addr_in,
  output logic                  replay_valid_out,
  input  logic                  replay_ready_in,
  output logic [PADDR_BITS-1:0] replay_addr_out,
  output logic                  replay_we_out,
  output logic [63:0]           replay_value_out,
  output logic                  replay_last_out,
  output logic                  full_out,
  output logic                  empty_out
);
  localparam int OFF = $clog2(B);
  localparam int LW  = PADDR_BITS - OFF;
  localparam int IW  = MSHR_COUNT > 1 ? $clog2(MSHR_COUNT) : 1;
  localparam int TW  = TARGETS > 1 ? $clog2(TARGETS) : 1;
  localparam int CW  = $clog2(TARGETS + 1);
  typedef enum logic [1:0] {FREE, PENDING, WAITING, REPLAY} st_t;
  st_t            st    [MSHR_COUNT];
  logic [LW-1:0]  line  [MSHR_COUNT];
  logic [CW-1:0]  cnt   [MSHR_COUNT];
  logic [OFF-1:0] t_off [MSHR_COUNT][TARGETS];
  logic           t_we  [MSHR_COUNT][TARGETS];
  logic [63:0]    t_val [MSHR_COUNT][TARGETS];
  logic [TW-1:0]  ptr;
  logic           lock;
  logic [IW-1:0]  cur;
  logic [LW-1:0]  req_line, fill_line;
  logic           hit, hit_ok, free_any, all_free, pend_any, rep_any;
  logic [IW-1:0]  hit_idx, free_idx, pend_idx, rep_idx, sel;
  logic           acc, alloc, rhs, rdone;
  logic           unused_fill_off;
  assign unused_fill_off = ^fill_addr_in[OFF-1:0];
  assign req_line  = req_addr_in[PADDR_BITS-1:OFF];
  assign fill_line = fill_addr_in[PADDR_BITS-1:OFF];
  // Descending scan so the lowest index wins every priority pick
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    all_free = 1'b1;
    pend_any = 1'b0;
    pend_idx = '0;
    rep_any  = 1'b0;
    rep_idx  = '0;
    for (int i = MSHR_COUNT - 1; i >= 0; i--) begin
      if (st[i] != FREE && line[i] == req_line) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (st[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      else all_free = 1'b0;
      if (st[i] == PENDING) begin
        pend_any = 1'b1;
        pend_idx = IW'(i);
      end
      if (st[i] == REPLAY) begin
        rep_any = 1'b1;
        rep_idx = IW'(i);
      end
    end
    hit_ok = (st[hit_idx] == PENDING || st[hit_idx] == WAITING) && cnt[hit_idx] < CW'(TARGETS);
  end
  assign req_ready_out    = hit ? hit_ok : free_any;
  assign acc              = req_valid_in & req_ready_out;
  assign alloc            = acc & ~hit;
  assign full_out         = ~free_any;
  assign empty_out        = all_free;
  assign lc_valid_out     = pend_any;
  assign lc_addr_out      = {line[pend_idx], {OFF{1'b0}}};
  // The replaying entry is locked until its last target so a newly filled lower entry cannot cut in
  assign sel              = lock ? cur : rep_idx;
  assign replay_valid_out = lock | rep_any;
  assign replay_addr_out  = {line[sel], t_off[sel][ptr]};
  assign replay_we_out    = t_we[sel][ptr];
  assign replay_value_out = replay_we_out ? t_val[sel][ptr] : 64'd0;
  assign replay_last_out  = replay_valid_out && (CW'(ptr) + 1'b1 == cnt[sel]);
  assign rhs              = replay_valid_out & replay_ready_in;
  assign rdone            = rhs & replay_last_out;
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < MSHR_COUNT; i++) begin
        st[i]  <= FREE;
        cnt[i] <= '0;
      end
      ptr  <= '0;
      lock <= 1'b0;
      cur  <= '0;
    end else begin
      for (int i = 0; i < MSHR_COUNT; i++) begin
        if (alloc && free_idx == IW'(i)) begin
          st[i]   <= PENDING;
          line[i] <= req_line;
          cnt[i]  <= CW'(1);
        end else begin
          if (acc && hit && hit_idx == IW'(i)) cnt[i] <= cnt[i] + 1'b1;
          if (lc_valid_out && lc_ready_in && pend_idx == IW'(i)) st[i] <= WAITING;
          if (fill_valid_in && st[i] == WAITING && line[i] == fill_line) st[i] <= REPLAY;
          if (rdone && sel == IW'(i)) begin
            st[i]  <= FREE;
            cnt[i] <= '0;
          end
        end
      end
      ptr  <= rdone ? '0 : rhs ? ptr + 1'b1 : ptr;
      lock <= replay_valid_out & ~rdone;
      cur  <= sel;
    end
  end
  always_ff @(posedge clk_in) begin
    if (acc) begin
      t_off[hit ? hit_idx : free_idx][hit ? TW'(cnt[hit_idx]) : '0] <= req_addr_in[OFF-1:0];
      t_we [hit ? hit_idx : free_idx][hit ? TW'(cnt[hit_idx]) : '0] <= req_we_in;
      t_val[hit ? hit_idx : free_idx][hit ? TW'(cnt[hit_idx]) : '0] <= req_value_in;
    end
  end
endmodule

// File: tb/tb_l1_mshr_file.sv
// tb_l1_mshr_file: directed vector table plus hand sequences for merge limits, full stall, stray fills, reset and replay back-pressure
module tb_l1_mshr_file;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        rv = 0, rwe = 0, lcr = 1, fv = 0, rr = 1;
  logic [21:0] ra = 0, fa = 0;
  logic [63:0] rval = 0;
  logic        rdy, lcv, rpv, rpwe, rplast, full, empty;
  logic [21:0] lca, rpa;
  logic [63:0] rpval;
  int          passed = 0, total = 0;

  l1_mshr_file dut (
    .clk_in(clk), .rst_N_in(rst_n),
    .req_valid_in(rv), .req_ready_out(rdy), .req_addr_in(ra), .req_we_in(rwe), .req_value_in(rval),
    .lc_valid_out(lcv), .lc_ready_in(lcr), .lc_addr_out(lca),
    .fill_valid_in(fv), .fill_addr_in(fa),
    .replay_valid_out(rpv), .replay_ready_in(rr), .replay_addr_out(rpa), .replay_we_out(rpwe),
    .replay_value_out(rpval), .replay_last_out(rplast), .full_out(full), .empty_out(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rv; logic [21:0] ra; logic we; logic [63:0] val; logic fv; logic [21:0] fa;
    logic e_rdy; logic e_lcv; logic [21:0] e_lca; logic e_rpv; logic [21:0] e_rpa;
    logic e_rwe; logic [63:0] e_rval; logic e_last; logic e_full; logic e_empty;
  } vec_t;
  vec_t tv [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [21:0] a, input logic w, input logic [63:0] d,
                       input logic f, input logic [21:0] fad, input logic r);
    @(negedge clk);
    rv = v; ra = a; rwe = w; rval = d; fv = f; fa = fad; rr = r;
    #1;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rv = 0; fv = 0; rr = 1; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_lc_valid", lcv, 0);
    chk("rst_replay_valid", rpv, 0);
    chk("rst_replay_last", rplast, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", rdy, 1);
  endtask

  task automatic chk_rp(input string name, input logic [21:0] a, input logic w, input logic [63:0] d, input logic l);
    chk({name, "_valid"}, rpv, 1);
    chk({name, "_addr"}, rpa, a);
    chk({name, "_we"}, rpwe, w);
    chk({name, "_value"}, rpval, d);
    chk({name, "_last"}, rplast, l);
  endtask

  initial begin
    tv[0]  = '{1, 'h1008, 0, 0,       0, 0,       1, 0, 0,       0, 0,       0, 0,       0, 0, 1};
    tv[1]  = '{0, 0,      0, 0,       0, 0,       1, 1, 'h1000,  0, 0,       0, 0,       0, 0, 0};
    tv[2]  = '{0, 0,      0, 0,       1, 'h1000,  1, 0, 0,       0, 0,       0, 0,       0, 0, 0};
    tv[3]  = '{0, 0,      0, 0,       0, 0,       1, 0, 0,       1, 'h1008,  0, 0,       1, 0, 0};
    tv[4]  = '{0, 0,      0, 0,       0, 0,       1, 0, 0,       0, 0,       0, 0,       0, 0, 1};
    tv[5]  = '{1, 'h2000, 0, 0,       0, 0,       1, 0, 0,       0, 0,       0, 0,       0, 0, 1};
    tv[6]  = '{1, 'h2010, 1, 'hAAAA,  0, 0,       1, 1, 'h2000,  0, 0,       0, 0,       0, 0, 0};
    tv[7]  = '{1, 'h2038, 0, 0,       0, 0,       1, 0, 0,       0, 0,       0, 0,       0, 0, 0};
    tv[8]  = '{0, 0,      0, 0,       1, 'h2000,  1, 0, 0,       0, 0,       0, 0,       0, 0, 0};
    tv[9]  = '{0, 0,      0, 0,       0, 0,       1, 0, 0,       1, 'h2000,  0, 0,       0, 0, 0};
    tv[10] = '{0, 0,      0, 0,       0, 0,       1, 0, 0,       1, 'h2010,  1, 'hAAAA,  0, 0, 0};
    tv[11] = '{0, 0,      0, 0,       0, 0,       1, 0, 0,       1, 'h2038,  0, 0,       1, 0, 0};
    tv[12] = '{0, 0,      0, 0,       0, 0,       1, 0, 0,       0, 0,       0, 0,       0, 0, 1};
    do_reset;
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].rv, tv[i].ra, tv[i].we, tv[i].val, tv[i].fv, tv[i].fa, 1);
      if (tv[i].rv) chk($sformatf("v%0d_ready", i), rdy, tv[i].e_rdy);
      chk($sformatf("v%0d_lc_valid", i), lcv, tv[i].e_lcv);
      if (tv[i].e_lcv) chk($sformatf("v%0d_lc_addr", i), lca, tv[i].e_lca);
      chk($sformatf("v%0d_rp_valid", i), rpv, tv[i].e_rpv);
      if (tv[i].e_rpv) begin
        chk($sformatf("v%0d_rp_addr", i), rpa, tv[i].e_rpa);
        chk($sformatf("v%0d_rp_we", i), rpwe, tv[i].e_rwe);
        chk($sformatf("v%0d_rp_value", i), rpval, tv[i].e_rval);
        chk($sformatf("v%0d_rp_last", i), rplast, tv[i].e_last);
      end
      chk($sformatf("v%0d_full", i), full, tv[i].e_full);
      chk($sformatf("v%0d_empty", i), empty, tv[i].e_empty);
    end

    // Merge limit: fifth target to a line stalls until that entry has fully replayed
    for (int k = 0; k < 4; k++) begin
      drive(1, 22'h2000 + 22'(8 * k), 0, 0, 0, 0, 1);
      chk($sformatf("t3_accept%0d", k), rdy, 1);
      if (k == 1) chk("t3_lc_addr", lca, 'h2000);
    end
    drive(1, 'h2030, 0, 0, 0, 0, 1);
    chk("t3_stall_count", rdy, 0);
    drive(1, 'h2030, 0, 0, 1, 'h2000, 1);
    chk("t3_stall_fill", rdy, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 'h2030, 0, 0, 0, 0, 1);
      chk($sformatf("t3_stall_replay%0d", k), rdy, 0);
      chk_rp($sformatf("t3_rp%0d", k), 22'h2000 + 22'(8 * k), 0, 0, k == 3);
    end
    drive(1, 'h2030, 0, 0, 0, 0, 1);
    chk("t3_realloc", rdy, 1);
    chk("t3_realloc_empty", empty, 1);
    chk("t3_realloc_lc_idle", lcv, 0);
    idle;
    chk("t3_new_lc_valid", lcv, 1);
    chk("t3_new_lc_addr", lca, 'h2000);
    drive(0, 0, 0, 0, 1, 'h2000, 1);
    idle;
    chk_rp("t3_new_rp", 'h2030, 0, 0, 1);
    idle;
    chk("t3_done_empty", empty, 1);

    // Full file: new line stalls, merge to an existing line still accepted
    for (int k = 1; k <= 4; k++) begin
      drive(1, 22'(k * 'h1000), 0, 0, 0, 0, 1);
      chk($sformatf("t4_alloc%0d", k), rdy, 1);
      chk($sformatf("t4_not_full%0d", k), full, 0);
    end
    drive(1, 'h5000, 0, 0, 0, 0, 1);
    chk("t4_full", full, 1);
    chk("t4_stall_new", rdy, 0);
    drive(1, 'h3008, 0, 0, 0, 0, 1);
    chk("t4_merge_when_full", rdy, 1);
    do_reset;

    // Stray fill is ignored; reset drops a WAITING entry and its later fill
    drive(1, 'h6000, 0, 0, 0, 0, 1);
    idle;
    chk("t5_lc_addr", lca, 'h6000);
    drive(0, 0, 0, 0, 1, 'h7000, 1);
    idle;
    chk("t5_stray_no_replay", rpv, 0);
    chk("t5_stray_not_empty", empty, 0);
    chk("t5_stray_lc_idle", lcv, 0);
    do_reset;
    drive(0, 0, 0, 0, 1, 'h6000, 1);
    idle;
    chk("t5_dropped_no_replay", rpv, 0);
    chk("t5_dropped_empty", empty, 1);

    // Replay back-pressure holds outputs; same-line miss stalls until entry is FREE
    drive(1, 'h3000, 0, 0, 0, 0, 1);
    chk("t6_alloc", rdy, 1);
    drive(1, 'h3008, 1, 'h55, 0, 0, 1);
    chk("t6_merge", rdy, 1);
    drive(0, 0, 0, 0, 1, 'h3000, 1);
    idle;
    chk_rp("t6_rp0", 'h3000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 'h3010, 0, 0, 0, 0, 0);
      chk_rp($sformatf("t6_hold%0d", k), 'h3008, 1, 'h55, 1);
      chk($sformatf("t6_stall%0d", k), rdy, 0);
    end
    drive(1, 'h3010, 0, 0, 0, 0, 1);
    chk_rp("t6_rp1", 'h3008, 1, 'h55, 1);
    chk("t6_stall_last", rdy, 0);
    drive(1, 'h3010, 0, 0, 0, 0, 1);
    chk("t6_after_free", rdy, 1);
    chk("t6_after_no_replay", rpv, 0);
    do_reset;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
